// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serialises a byte stream LSB-first onto the CLB configuration chain.
// Define CFG_READBACK_EN to add rd_valid/rd_data, streaming the previous chain contents back out.
module cfg_chain_loader #(
    parameter int  NUM_CLB      = 4,
    parameter int  CLB_CFG_BITS = 17,
    localparam int CHAIN_BITS   = NUM_CLB * CLB_CFG_BITS,
    localparam int CW           = $clog2(CHAIN_BITS + 1)
) (
    input  logic       prog_clk,
    input  logic       prog_rst_n,
    input  logic       start,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       prog_in,
    output logic       prog_en,
    input  logic       chain_out,
    output logic       busy,
    output logic       cfg_done
`ifdef CFG_READBACK_EN
    ,
    output logic       rd_valid,
    output logic [7:0] rd_data
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_bits;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_prog_en, r_prog_in, r_done;
    logic          w_busy, w_ready, w_start, w_last, w_final;

    // A burst ends on the 8th bit of a byte or on the last bit of the whole chain.
    assign w_final = (r_bits == CW'(CHAIN_BITS - 1));
    assign w_last  = (r_idx == 3'd7) || w_final;

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_busy  = (r_state == FETCH) || (r_state == SHIFT);
        w_ready = (r_state == FETCH);
        w_start = start && !w_busy;
        w_next  = r_state;
        case (r_state)
            IDLE, DONE: w_next = w_start ? FETCH : IDLE;
            FETCH:      w_next = s_valid ? SHIFT : FETCH;
            SHIFT:      w_next = !w_last ? SHIFT : (w_final ? DONE : FETCH);
            default:    w_next = IDLE;
        endcase
    end

    // prog_en/prog_in are registered so that they are high exactly during SHIFT cycles.
    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            r_bits    <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_prog_en <= 1'b0;
            r_prog_in <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_start) begin
                r_bits <= '0;
                r_done <= 1'b0;
            end
            if (w_ready && s_valid) begin
                r_shift   <= s_data;
                r_prog_in <= s_data[0];
                r_prog_en <= 1'b1;
                r_idx     <= '0;
            end
            if (r_state == SHIFT) begin
                r_shift   <= r_shift >> 1;
                r_prog_in <= w_last ? 1'b0 : r_shift[1];
                r_prog_en <= !w_last;
                r_bits    <= r_bits + CW'(1);
                r_idx     <= r_idx + 3'd1;
            end
            if (w_next == DONE)
                r_done <= 1'b1;
        end
    end

    assign s_ready  = w_ready;
    assign busy     = w_busy;
    assign prog_en  = r_prog_en;
    assign prog_in  = r_prog_in;
    assign cfg_done = r_done;

`ifdef CFG_READBACK_EN
    logic [7:0] r_rb, r_rd_data, w_rb;
    logic       r_rd_valid;

    // Readback bytes share the load's byte alignment, so r_idx is the bit position.
    assign w_rb = ((r_idx == 3'd0) ? 8'h00 : r_rb) | (8'(chain_out) << r_idx);

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            r_rb       <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= (r_state == SHIFT) && w_last;
            if (r_state == SHIFT) begin
                r_rb <= w_rb;
                if (w_last)
                    r_rd_data <= w_rb;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
`else
    logic w_unused;
    assign w_unused = chain_out;
`endif
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: scoreboard bench driving byte loads into cfg_chain_loader
// against a model of four 17-bit CLB shift registers.
module tb_cfg_chain_loader;
    logic       prog_clk = 1'b0;
    logic       prog_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, prog_in, prog_en, busy, cfg_done, chain_out;
`ifdef CFG_READBACK_EN
    logic       rd_valid;
    logic [7:0] rd_data;
`endif

    cfg_chain_loader dut (
        .prog_clk  (prog_clk),
        .prog_rst_n(prog_rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .prog_in   (prog_in),
        .prog_en   (prog_en),
        .chain_out (chain_out),
        .busy      (busy),
        .cfg_done  (cfg_done)
`ifdef CFG_READBACK_EN
        ,
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    int         checks = 0, failures = 0;
    bit         exp_q[$];
    logic [7:0] rd_q[$];
    bit         exp_bit;
    int         en_cnt = 0, run = 0, bursts = 0, hs_cnt = 0, busy_cnt = 0;
    int         done_rises = 0, rd_cnt = 0, sent = 0;
    bit         prev_done = 1'b0, chk_burst = 1'b1, rd_on = 1'b0;

    // Chain model: CLB0 fed by prog_in, each CLB shifts toward bit 0, chain_out is CLB3 bit 0.
    logic [16:0] clb[4] = '{default: 17'h0};
    always @(posedge prog_clk) begin
        if (prog_en) begin
            clb[0] <= {prog_in, clb[0][16:1]};
            for (int k = 1; k < 4; k++) clb[k] <= {clb[k-1][0], clb[k][16:1]};
        end
    end
    assign chain_out = clb[3][0];

    always @(negedge prog_clk) begin
        if (prog_en) begin
            run++;
            en_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL shift_extra: prog_en=1 with no bit expected, prog_in=%b", prog_in);
            end else begin
                exp_bit = exp_q.pop_front();
                if (prog_in !== exp_bit) begin
                    failures++;
                    $display("FAIL prog_in_bit%0d: got %b expected %b", en_cnt - 1, prog_in, exp_bit);
                end
            end
        end else if (run > 0) begin
            bursts++;
            if (chk_burst) begin
                checks++;
                if (run != 8 && !(run == 4 && en_cnt == 68)) begin
                    failures++;
                    $display("FAIL burst_len: got %0d (total %0d) expected 8, or 4 at total 68", run, en_cnt);
                end
            end
            run = 0;
        end
        if (s_valid && s_ready) hs_cnt++;
        if (busy) busy_cnt++;
        if (cfg_done && !prev_done) done_rises++;
        prev_done = cfg_done;
`ifdef CFG_READBACK_EN
        if (rd_valid && rd_on) begin
            rd_cnt++;
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_extra: rd_data=%h with nothing expected", rd_data);
            end else if (rd_data !== rd_q[0]) begin
                failures++;
                $display("FAIL rd_data%0d: got %h expected %h", rd_cnt - 1, rd_data, rd_q.pop_front());
            end else begin
                void'(rd_q.pop_front());
            end
        end
`endif
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && t < 200) begin
            @(negedge prog_clk);
            t++;
        end
        checks++;
        if (!s_ready) begin
            failures++;
            $display("FAIL handshake_timeout: s_ready=%b expected 1", s_ready);
        end else begin
            @(posedge prog_clk);
            #1;
            for (int i = 0; i < ((68 - sent) < 8 ? (68 - sent) : 8); i++) exp_q.push_back(b[i]);
            sent += ((68 - sent) < 8 ? (68 - sent) : 8);
        end
    endtask

    task automatic check_chain(input logic [7:0] b[9], input string tag);
        logic [71:0] st;
        for (int i = 0; i < 9; i++) st[8*i +: 8] = b[i];
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (clb[k] !== st[17*(3-k) +: 17]) begin
                failures++;
                $display("FAIL %s_clb%0d: got %h expected %h", tag, k, clb[k], st[17*(3-k) +: 17]);
            end
        end
    endtask

    task automatic do_load(input logic [7:0] b[9], input int stall_after, input int restart_at,
                           input int exp_busy, input string tag);
        int t = 0;
        en_cnt = 0; bursts = 0; hs_cnt = 0; busy_cnt = 0; done_rises = 0; sent = 0;
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send_byte(b[i]);
            if (i == restart_at) begin
                start = 1'b1;
                @(posedge prog_clk);
                #1;
                start = 1'b0;
            end
            if (i == stall_after) begin
                s_valid = 1'b0;
                t = 0;
                while (!s_ready && t < 20) begin
                    @(negedge prog_clk);
                    t++;
                end
                for (int g = 0; g < 5; g++) begin
                    checks++;
                    if (prog_en !== 1'b0 || s_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL %s_stall%0d: prog_en=%b s_ready=%b expected 0/1", tag, g, prog_en, s_ready);
                    end
                    @(negedge prog_clk);
                end
            end
        end
        t = 0;
        while (!cfg_done && t < 100) begin
            @(negedge prog_clk);
            t++;
        end
        checks++;
        if (cfg_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout: cfg_done=%b expected 1", tag, cfg_done);
        end
        s_valid = 1'b0;
        repeat (3) @(negedge prog_clk);
        checks++;
        if (hs_cnt !== 9 || en_cnt !== 68 || bursts !== 9) begin
            failures++;
            $display("FAIL %s_counts: bytes=%0d shifts=%0d bursts=%0d expected 9/68/9", tag, hs_cnt, en_cnt, bursts);
        end
        checks++;
        if (done_rises !== 1 || cfg_done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: rises=%0d cfg_done=%b busy=%b expected 1/1/0", tag, done_rises, cfg_done, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_leftover: %0d bits not shifted, expected 0", tag, exp_q.size());
        end
        if (exp_busy > 0) begin
            checks++;
            if (busy_cnt !== exp_busy) begin
                failures++;
                $display("FAIL %s_busy_cycles: got %0d expected %0d", tag, busy_cnt, exp_busy);
            end
        end
        check_chain(b, tag);
    endtask

    task automatic test_reset;
        prog_rst_n = 1'b0;
        start      = 1'b1;
        s_valid    = 1'b1;
        s_data     = 8'hA5;
        repeat (3) @(negedge prog_clk);
        checks++;
        if ({s_ready, prog_en, prog_in, busy, cfg_done} !== 5'b0 || hs_cnt !== 0) begin
            failures++;
            $display("FAIL reset_outputs: ready/en/in/busy/done=%b bytes=%0d expected 00000/0",
                     {s_ready, prog_en, prog_in, busy, cfg_done}, hs_cnt);
        end
`ifdef CFG_READBACK_EN
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_readback: rd_valid=%b rd_data=%h expected 0/00", rd_valid, rd_data);
        end
`endif
        prog_rst_n = 1'b1;
        start      = 1'b0;
        s_valid    = 1'b0;
        repeat (2) @(negedge prog_clk);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b s_ready=%b expected 0/0", busy, s_ready);
        end
    endtask

    task automatic test_basic;
        logic [7:0] b[9];
        for (int i = 0; i < 9; i++) b[i] = 8'(i + 1);
        do_load(b, -1, -1, 77, "basic");
    endtask

    task automatic test_stall;
        logic [7:0] b[9];
        for (int i = 0; i < 9; i++) b[i] = 8'(i + 1);
        do_load(b, 2, -1, 82, "stall");
    endtask

    task automatic test_ignored_start;
        logic [7:0] b[9];
        for (int i = 0; i < 9; i++) b[i] = 8'(8'h3C ^ (i * 37));
        do_load(b, -1, 4, 77, "restart");
    endtask

    task automatic test_reset_mid_load;
        logic [7:0] b[9];
        en_cnt = 0; sent = 0;
        chk_burst = 1'b0;
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'(8'h50 + i));
        repeat (3) @(negedge prog_clk);
        prog_rst_n = 1'b0;
        @(negedge prog_clk);
        checks++;
        if (prog_en !== 1'b0 || busy !== 1'b0 || cfg_done !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset: prog_en=%b busy=%b cfg_done=%b s_ready=%b expected 0000",
                     prog_en, busy, cfg_done, s_ready);
        end
        prog_rst_n = 1'b1;
        s_valid    = 1'b0;
        exp_q.delete();
        @(negedge prog_clk);
        chk_burst = 1'b1;
        for (int i = 0; i < 9; i++) b[i] = 8'hFF;
        do_load(b, -1, -1, 77, "ones");
    endtask

`ifdef CFG_READBACK_EN
    task automatic test_readback;
        logic [7:0] a[9], b[9];
        for (int i = 0; i < 9; i++) begin
            a[i] = 8'(8'hC3 + 8'(i * 29));
            b[i] = 8'(8'h5A ^ 8'(i * 71));
        end
        do_load(a, -1, -1, 0, "rb_a");
        rd_q.delete();
        for (int i = 0; i < 9; i++) rd_q.push_back(i == 8 ? (a[i] & 8'h0F) : a[i]);
        rd_cnt = 0;
        rd_on  = 1'b1;
        do_load(b, -1, -1, 0, "rb_b");
        rd_on = 1'b0;
        checks++;
        if (rd_cnt !== 9 || rd_q.size() != 0) begin
            failures++;
            $display("FAIL rd_count: pulses=%0d pending=%0d expected 9/0", rd_cnt, rd_q.size());
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_ignored_start;
        test_reset_mid_load;
`ifdef CFG_READBACK_EN
        test_readback;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Configuration controller that sits directly upstream of the CLB configuration chain.
- Accepts the bitstream as bytes over a valid/ready stream and serialises it onto the chain's prog_in/prog_en pins.
- Loads exactly NUM_CLB*CLB_CFG_BITS bits, then flags completion.
- The chain is clocked by the same prog_clk, so prog_en is a shift qualifier, not a clock gate.

Parameters:
- NUM_CLB, 4, number of CLBs daisy-chained (prog_out of CLB i drives prog_in of CLB i+1).
- CLB_CFG_BITS, 17, configuration bits per CLB (16 LUT bits + 1 output-mux select).
- CHAIN_BITS, NUM_CLB*CLB_CFG_BITS, derived; total bits shifted per load. Not to be overridden.

Ports:
- prog_clk  in  1  single clock; also clocks the CLB chain.
- prog_rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy=1.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  bitstream byte, shifted LSB first.
- s_ready  out  1  byte accepted on the edge where s_valid&s_ready=1.
- prog_in  out  1  serial bit to the first CLB (registered).
- prog_en  out  1  chain shift enable (registered).
- chain_out  in  1  prog_out of the last CLB in the chain.
- busy  out  1  high from the cycle after an accepted start until the final shift completes.
- cfg_done  out  1  level; high after a complete load, cleared by the next accepted start or by reset.

Behaviour:
- Reset (prog_rst_n=0 at a prog_clk edge) forces the following on the next edge:
  - state=IDLE
  - s_ready=0, prog_en=0, prog_in=0, busy=0, cfg_done=0
  - bit counter=0, byte shifter=0
- Reset mid-load aborts immediately. prog_en drops on that edge and the chain holds whatever partial contents it had. No recovery; a new start reloads from bit 0.
- State IDLE:
  - Accepted start → FETCH on the next edge; busy=1, cfg_done=0, bit counter=0.
- State FETCH:
  - s_ready=1, prog_en=0.
  - On s_valid&s_ready: latch s_data into the shifter, compute n = min(8, CHAIN_BITS - bits_sent), go to SHIFT.
- State SHIFT, for n consecutive cycles:
  - prog_en=1 and prog_in=shifter[0]; the shifter shifts right and the bit counter increments each cycle.
  - s_ready=0 throughout.
  - After the n-th bit:
    - if bits_sent == CHAIN_BITS, go to DONE;
    - otherwise go to FETCH.
- State DONE (one cycle):
  - prog_en=0, busy=0, cfg_done=1; then go to IDLE.
- Byte count and partial final byte:
  - Exactly ceil(CHAIN_BITS/8) bytes are consumed per load; default is 9 bytes.
  - In the final byte only the low (CHAIN_BITS mod 8) bits are shifted; default is 4 bits, bits 7:4 discarded.
  - If CHAIN_BITS is a multiple of 8, the final byte is full.
- Throughput: 1 byte per 9 cycles (1 FETCH cycle + 8 SHIFT cycles) when s_valid is held high.
- If s_valid is low in FETCH, stay in FETCH with prog_en=0 and the chain holding. Stalls are unbounded and safe.
- Bit ordering: the first bit shifted ends in the last CLB's bit 0 (output-mux select). The bitstream is therefore last-CLB-first, mux-select-first, then LUT bit 0..15.
- start while busy=1 is ignored, with no effect on state or outputs.
- start in the same cycle as reset: reset wins.
- Bit counter width: $clog2(CHAIN_BITS+1); it never wraps.

Optional Feature:
- Macro: CFG_READBACK_EN.
- When defined, two extra ports are added:
  - rd_valid  out  1
  - rd_data  out  8
- Readback behaviour:
  - On every cycle with prog_en=1, chain_out is captured LSB-first into a readback shifter. This streams out the previous configuration as the new one shifts in.
  - rd_valid pulses for one cycle, the cycle after each 8th captured bit and after the final captured bit of a load. A partial final byte is zero-padded in its high bits.
  - There is no backpressure.
  - Reset clears rd_valid and rd_data to 0.
- When undefined, the ports and logic are absent and chain_out is unused.

Test Plan:
- Reset with s_valid=1 and start=1 held → all outputs 0 on the edge after reset; no byte accepted.
- start, 9 bytes 0x01..0x09 back-to-back →
  - 68 prog_en cycles, each in a burst of 8 except the last burst of 4;
  - prog_in sequence = LSB-first bits of each byte, with 0x09 contributing 1,0,0,1;
  - cfg_done=1 after the final burst;
  - a model of 4 CLB shift registers matches.
- s_valid dropped for 5 cycles between bytes 3 and 4 → prog_en=0 during the gap; final chain contents identical to the unstalled run.
- Second start pulse during byte 5 → ignored; byte count stays 9 and cfg_done asserts once.
- prog_rst_n low during byte 6 → prog_en=0, busy=0, cfg_done=0 on the next edge. A new start with 9 bytes of 0xFF yields all-ones in all 4 CLBs.
- (CFG_READBACK_EN) Load pattern A, then load pattern B → during the B load, rd_valid pulses 9 times and the rd_data bytes reproduce pattern A, with the final byte masked to 4 bits.
